// File: rtl/cache_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_port_arbiter_if
//   Bundles the two requester ports (fetch I, data D), the cache controller
//   request/response port and the arbiter status flags.
//
//   Requester I : i_req, i_addr            -> i_ack, i_rdata, i_hit
//   Requester D : d_req, d_wr, d_addr,
//                 d_wdata                  -> d_ack, d_rdata, d_hit
//   Controller  : c_Addr, c_DataIn, c_Rd,
//                 c_Wr                     <- c_Done, c_CacheHit, c_DataOut
//   Status      : busy, err
//
//   slave  : the arbiter side
//   master : the environment side (pipeline stages + cache controller)
// -----------------------------------------------------------------------------
interface cache_port_arbiter_if;
    // Fetch port
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        i_hit;
    // Data port
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        d_hit;
    // Cache controller port
    logic [15:0] c_Addr;
    logic [15:0] c_DataIn;
    logic        c_Rd;
    logic        c_Wr;
    logic        c_Done;
    logic        c_CacheHit;
    logic [15:0] c_DataOut;
    // Status
    logic        busy;
    logic        err;

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_rdata, i_hit,
        input  d_req, d_wr, d_addr, d_wdata,
        output d_ack, d_rdata, d_hit,
        output c_Addr, c_DataIn, c_Rd, c_Wr,
        input  c_Done, c_CacheHit, c_DataOut,
        output busy, err
    );

    modport master (
        output i_req, i_addr,
        input  i_ack, i_rdata, i_hit,
        output d_req, d_wr, d_addr, d_wdata,
        input  d_ack, d_rdata, d_hit,
        input  c_Addr, c_DataIn, c_Rd, c_Wr,
        output c_Done, c_CacheHit, c_DataOut,
        input  busy, err
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// cache_port_arbiter
//   Shares the single cache controller request port between instruction fetch
//   (port I, read-only) and data memory (port D, read/write). Round-robin on
//   contention, the granted request is latched and held on the controller
//   port until c_Done, and a watchdog aborts a transaction the controller
//   never completes.
//
//   Parameters
//     TIMEOUT : BUSY cycles without c_Done before the transaction is aborted
//     CNT_W   : watchdog counter width (must hold TIMEOUT-1)
//
//   Ports
//     clk : system clock, rising edge
//     rst : asynchronous reset, active low
//     bus : cache_port_arbiter_if.slave (requesters, controller, status)
// -----------------------------------------------------------------------------
module cache_port_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_port_arbiter_if.slave   bus
);

    typedef enum logic {
        ARB  = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    port_t            r_last_grant;
    port_t            r_gnt;
    logic [15:0]      r_addr;
    logic [15:0]      r_wdata;
    logic             r_wr;
    logic             r_c_rd;
    logic             r_c_wr;
    logic [CNT_W-1:0] r_wdog;
    logic             r_err;
    logic [15:0]      r_i_rdata;
    logic [15:0]      r_d_rdata;

    logic             w_busy;
    logic             w_done;
    logic             w_timeout;
    logic             w_finish;
    logic             w_req_any;
    port_t            w_pick;
    logic [15:0]      w_rdata;
    logic             w_hit;

    // -------------------------------------------------------------------------
    // Arbitration: a lone requester wins; on a tie the port that was not
    // granted last time wins.
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_req_any = bus.i_req | bus.d_req;
        w_pick    = PORT_I;
        if (bus.i_req && bus.d_req)
            w_pick = (r_last_grant == PORT_D) ? PORT_I : PORT_D;
        else if (bus.d_req)
            w_pick = PORT_D;
    end

    // -------------------------------------------------------------------------
    // Completion. c_Done only counts while BUSY. A real c_Done on the last
    // watchdog cycle beats the timeout, so good data is never discarded.
    // -------------------------------------------------------------------------
    assign w_busy    = (r_state == BUSY);
    assign w_done    = w_busy & bus.c_Done;
    assign w_timeout = w_busy & ~bus.c_Done & (r_wdog == WDOG_LAST);
    assign w_finish  = w_done | w_timeout;

    // An aborted transaction returns zero data and no hit.
    assign w_rdata   = w_done ? bus.c_DataOut : 16'h0000;
    assign w_hit     = w_done & bus.c_CacheHit;

    // Acks are combinational so the requester sees completion in the same
    // cycle the controller raises c_Done.
    assign bus.i_ack   = w_finish & (r_gnt == PORT_I);
    assign bus.d_ack   = w_finish & (r_gnt == PORT_D);
    assign bus.i_hit   = bus.i_ack & w_hit;
    assign bus.d_hit   = bus.d_ack & w_hit;
    // Read data holds its last value between acks.
    assign bus.i_rdata = bus.i_ack ? w_rdata : r_i_rdata;
    assign bus.d_rdata = bus.d_ack ? w_rdata : r_d_rdata;

    // Controller port comes straight from flops.
    assign bus.c_Addr   = r_addr;
    assign bus.c_DataIn = r_wdata;
    assign bus.c_Rd     = r_c_rd;
    assign bus.c_Wr     = r_c_wr;

    assign bus.busy = w_busy;
    // err is visible in the abort cycle itself, then held by the sticky flop.
    assign bus.err  = r_err | w_timeout;

    // -------------------------------------------------------------------------
    // Control FSM and request latch
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ARB;
            r_last_grant <= PORT_D;
            r_gnt        <= PORT_I;
            r_addr       <= 16'h0000;
            r_wdata      <= 16'h0000;
            r_wr         <= 1'b0;
            r_c_rd       <= 1'b0;
            r_c_wr       <= 1'b0;
            r_wdog       <= '0;
            r_err        <= 1'b0;
            r_i_rdata    <= 16'h0000;
            r_d_rdata    <= 16'h0000;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_req_any) begin
                        r_gnt        <= w_pick;
                        r_last_grant <= w_pick;
                        if (w_pick == PORT_D) begin
                            r_addr  <= bus.d_addr;
                            r_wdata <= bus.d_wdata;
                            r_wr    <= bus.d_wr;
                            r_c_rd  <= ~bus.d_wr;
                            r_c_wr  <= bus.d_wr;
                        end else begin
                            r_addr  <= bus.i_addr;
                            r_wdata <= 16'h0000;
                            r_wr    <= 1'b0;
                            r_c_rd  <= 1'b1;
                            r_c_wr  <= 1'b0;
                        end
                        r_wdog  <= '0;
                        r_state <= BUSY;
                    end
                end

                BUSY: begin
                    if (w_finish) begin
                        // Dropping Rd/Wr here guarantees the one-cycle idle
                        // gap before the next grant reaches the controller.
                        r_c_rd  <= 1'b0;
                        r_c_wr  <= 1'b0;
                        r_wdog  <= '0;
                        r_state <= ARB;
                        if (w_timeout)
                            r_err <= 1'b1;
                        if (r_gnt == PORT_I)
                            r_i_rdata <= w_rdata;
                        else
                            r_d_rdata <= w_rdata;
                    end else begin
                        r_wdog <= r_wdog + CNT_W'(1);
                    end
                end

                default: r_state <= ARB;
            endcase
        end
    end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single cache controller request port between two requesters: instruction fetch (port I, read-only) and data memory (port D, read/write).
- Sits between the fetch/memory pipeline stages and the cache controller.
- Drives the controller's Addr/DataIn/Rd/Wr and consumes Done/CacheHit/DataOut.
- Round-robin on contention; holds the granted request stable until Done; watchdog flags a hung transaction.

Parameters:
TIMEOUT, 64, max cycles in BUSY without c_Done before abort (≥ 20)
CNT_W, 7, width of watchdog counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, all flops rising-edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
i_req  in  1  fetch request; held with i_addr until i_ack
i_addr  in  16  fetch address
i_ack  out  1  one-cycle completion pulse for port I
i_rdata  out  16  read data, valid with i_ack
i_hit  out  1  CacheHit for port I, valid with i_ack
d_req  in  1  data request; held with d_wr/d_addr/d_wdata until d_ack
d_wr  in  1  1 = write, 0 = read
d_addr  in  16  data address
d_wdata  in  16  write data
d_ack  out  1  one-cycle completion pulse for port D
d_rdata  out  16  read data, valid with d_ack
d_hit  out  1  CacheHit for port D, valid with d_ack
c_Addr  out  16  address to cache controller
c_DataIn  out  16  write data to cache controller
c_Rd  out  1  read request to cache controller
c_Wr  out  1  write request to cache controller
c_Done  in  1  controller completion pulse
c_CacheHit  in  1  controller hit flag, valid with c_Done
c_DataOut  in  16  controller read data, valid with c_Done
busy  out  1  1 while in BUSY
err  out  1  sticky watchdog error, cleared only by reset

Behaviour:
- Reset: state ARB, last_grant = D (so I wins first tie), all latches 0, watchdog 0. Outputs low: c_Rd, c_Wr, i_ack, d_ack, busy, err. Data buses 0.
- States: ARB, BUSY. Grant and request fields are registered; all c_* outputs derive from flops only.
- ARB:
  - c_Rd = c_Wr = 0.
  - One requester: grant it.
  - Both: grant the port not equal to last_grant.
  - On grant: latch port, addr, wr (I: 0), wdata (I: 0); update last_grant; go to BUSY. Neither: stay.
- BUSY:
  - c_Addr / c_DataIn from latch.
  - c_Rd = ~wr_q, c_Wr = wr_q; held at a constant level every BUSY cycle, including the c_Done cycle.
  - Watchdog increments each cycle.
  - On c_Done: pulse the granted port's ack for exactly one cycle, same cycle as c_Done (combinational from c_Done & grant). rdata = c_DataOut, hit = c_CacheHit. Watchdog cleared; next state ARB.
- Gap: ARB always lasts ≥1 cycle with c_Rd = c_Wr = 0, so the controller sees requests low while idle after Done. Back-to-back service: Done → 1 gap cycle → next request asserted.
- Latency: request seen in cycle N (ARB) → c_Rd/c_Wr high in N+1. Requester ack = c_Done cycle.
- Request changes mid-transaction are ignored; the latch is used. A requester dropping req before ack is a protocol violation; the transaction still completes and ack still pulses.
- Watchdog: if counter reaches TIMEOUT−1 without c_Done:
  - set err;
  - pulse granted ack with rdata = 16'h0000, hit = 0;
  - return to ARB.
- Done outside BUSY: ignored, no ack.
- i_rdata/d_rdata hold last value between acks; i_hit/d_hit are 0 when ack is 0.
- rst low at any time: immediate return to reset values. An in-flight transaction is dropped with no ack.

Test Plan:
- Reset release, i_req=1, i_addr=16'h0040 → c_Rd=1, c_Addr=16'h0040 one cycle later. c_Done with c_DataOut=16'hBEEF, c_CacheHit=1 → i_ack=1, i_rdata=16'hBEEF, i_hit=1 same cycle; c_Rd=0 next cycle.
- i_req and d_req (write, 16'h1008, 16'h00AA) asserted together, held → I served first, then D with c_Wr=1, c_DataIn=16'h00AA. Exactly one gap cycle (c_Rd=c_Wr=0) between c_Done and c_Wr.
- Both held continuously for 4 transactions → grant order I, D, I, D; each ack single-cycle.
- d_addr changed to 16'hFFFF mid-BUSY → c_Addr stays at the latched value until c_Done.
- TIMEOUT=64, c_Done never asserted → on cycle 64 of BUSY, d_ack=1, d_rdata=0, err=1 and stays 1; next request serviced normally.
- rst driven low during BUSY → c_Rd, c_Wr, busy, acks go 0 asynchronously. After release, state ARB and I wins the first tie.
